pc_window_profiler: RTL and testbench

- Multi-channel hardware cycle profiler that watches the processor program counter.
- Counts clock cycles between a programmable start PC and stop PC, per channel.
- Sits beside processor_unpipelined inside soc and replaces bench-side $time start/stop measurement with in-silicon counters readable by bench or firmware.
- Supports single-shot and repeat (accumulate) modes, saturating counters and a completed-window count.

---
 rtl/pc_window_profiler.sv | 167 ++++++++++++++++
 tb/tb_pc_window_profiler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_window_profiler.sv
// pc_window_profiler
//   Multi-channel cycle profiler that watches the processor PC. Each channel
//   counts enabled cycles between a programmable start PC and stop PC. It
//   supports single-shot and repeat (accumulate) modes. Cycle and hit counters
//   saturate and set a sticky overflow flag.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   enable, pc            processor enable and current program counter
//   cfg_we/cfg_sel/...    per-channel start/stop/repeat configuration write
//   arm, clear            per-channel control pulses (clear beats arm)
//   rd_sel                readback channel select
//   rd_count/rd_hits/rd_state  registered readback of the selected channel
//   done, overflow        per-channel status (done decoded from state)

// One profiling window: FSM, counters and configuration registers.
module pc_window_channel #(
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   cfg_we,
  input  logic [ADDR_WIDTH-1:0]  cfg_start,
  input  logic [ADDR_WIDTH-1:0]  cfg_stop,
  input  logic                   cfg_repeat,
  input  logic                   arm,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [15:0]            hits,
  output logic [1:0]             state,
  output logic                   done,
  output logic                   overflow
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RUNNING = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [ADDR_WIDTH-1:0] start_pc;
  logic [ADDR_WIDTH-1:0] stop_pc;
  logic                  rep;
  logic                  quiet;

  // Configuration may only change while the window is not in flight.
  assign quiet = (state == ST_IDLE) || (state == ST_DONE);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      hits     <= '0;
      overflow <= 1'b0;
      start_pc <= '0;
      stop_pc  <= '0;
      rep      <= 1'b0;
    end else begin
      if (cfg_we && quiet) begin
        start_pc <= cfg_start;
        stop_pc  <= cfg_stop;
        rep      <= cfg_repeat;
      end
      if (clear) begin
        state    <= ST_IDLE;
        count    <= '0;
        hits     <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (arm) state <= ST_ARMED;
          // The start-match cycle is not counted and is never a stop match,
          // which makes start==stop measure the gap between visits.
          ST_ARMED: if (enable && pc == start_pc) state <= ST_RUNNING;
          ST_RUNNING: begin
            if (enable) begin
              if (count == COUNT_MAX) overflow <= 1'b1;
              else                    count    <= count + COUNT_WIDTH'(1);
              if (pc == stop_pc) begin
                if (hits == 16'hFFFF) overflow <= 1'b1;
                else                  hits     <= hits + 16'd1;
                // Repeat keeps the count so successive windows accumulate.
                state <= rep ? ST_ARMED : ST_DONE;
              end
            end
          end
          default: if (arm) state <= ST_ARMED; // DONE: re-arm keeps totals
        endcase
      end
    end
  end
endmodule

module pc_window_profiler #(
  parameter int ADDR_WIDTH   = 8,
  parameter int COUNT_WIDTH  = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int SEL_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   pc,
  input  logic                    cfg_we,
  input  logic [SEL_WIDTH-1:0]    cfg_sel,
  input  logic [ADDR_WIDTH-1:0]   cfg_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_stop,
  input  logic                    cfg_repeat,
  input  logic [NUM_CHANNELS-1:0] arm,
  input  logic [NUM_CHANNELS-1:0] clear,
  input  logic [SEL_WIDTH-1:0]    rd_sel,
  output logic [COUNT_WIDTH-1:0]  rd_count,
  output logic [15:0]             rd_hits,
  output logic [1:0]              rd_state,
  output logic [NUM_CHANNELS-1:0] done,
  output logic [NUM_CHANNELS-1:0] overflow
);
  logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] ch_count;
  logic [NUM_CHANNELS-1:0][15:0]            ch_hits;
  logic [NUM_CHANNELS-1:0][1:0]             ch_state;
  logic                                     rd_valid;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    // An out-of-range cfg_sel matches no channel, so the write is dropped.
    logic cfg_hit;
    assign cfg_hit = cfg_we && (cfg_sel == SEL_WIDTH'(g));

    pc_window_channel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .pc        (pc),
      .cfg_we    (cfg_hit),
      .cfg_start (cfg_start),
      .cfg_stop  (cfg_stop),
      .cfg_repeat(cfg_repeat),
      .arm       (arm[g]),
      .clear     (clear[g]),
      .count     (ch_count[g]),
      .hits      (ch_hits[g]),
      .state     (ch_state[g]),
      .done      (done[g]),
      .overflow  (overflow[g])
    );
  end

  assign rd_valid = (int'(rd_sel) < NUM_CHANNELS);

  always_ff @(posedge clk) begin
    if (reset || !rd_valid) begin
      rd_count <= '0;
      rd_hits  <= '0;
      rd_state <= '0;
    end else begin
      rd_count <= ch_count[rd_sel];
      rd_hits  <= ch_hits[rd_sel];
      rd_state <= ch_state[rd_sel];
    end
  end
endmodule

// File: tb/tb_pc_window_profiler.sv
// Bench for pc_window_profiler. Two instances share stimulus: a wide-counter
// one and a 4-bit-counter one for saturation. The model keeps unbounded
// per-channel totals and derives saturated outputs and overflow from them.
module tb_pc_window_profiler;
  localparam int AW = 8, NCH = 3, SW = 2;
  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_RUN = 2, ST_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, enable, cfg_we, cfg_repeat;
  logic [AW-1:0]  pc, cfg_start, cfg_stop;
  logic [SW-1:0]  cfg_sel, rd_sel;
  logic [NCH-1:0] arm, clear;

  logic [7:0]     rd_count_a;
  logic [3:0]     rd_count_b;
  logic [15:0]    rd_hits_a, rd_hits_b;
  logic [1:0]     rd_state_a, rd_state_b;
  logic [NCH-1:0] done_a, done_b, ovf_a, ovf_b;

  pc_window_profiler #(.ADDR_WIDTH(AW), .COUNT_WIDTH(8), .NUM_CHANNELS(NCH)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pc(pc), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_repeat(cfg_repeat), .arm(arm), .clear(clear), .rd_sel(rd_sel),
    .rd_count(rd_count_a), .rd_hits(rd_hits_a), .rd_state(rd_state_a),
    .done(done_a), .overflow(ovf_a));

  pc_window_profiler #(.ADDR_WIDTH(AW), .COUNT_WIDTH(4), .NUM_CHANNELS(NCH)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pc(pc), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_repeat(cfg_repeat), .arm(arm), .clear(clear), .rd_sel(rd_sel),
    .rd_count(rd_count_b), .rd_hits(rd_hits_b), .rd_state(rd_state_b),
    .done(done_b), .overflow(ovf_b));

  int n_cmp = 0, n_err = 0, cyc = 0;

  // Behavioural model: true (unsaturated) totals per channel.
  int     m_state[NCH];
  longint m_cnt[NCH], m_hits[NCH];
  int     m_start[NCH], m_stop[NCH];
  bit     m_rep[NCH];
  longint e_cnt, e_hits;
  int     e_state;

  function automatic longint sat(longint v, longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit acc;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_state[c] = ST_IDLE; m_cnt[c] = 0; m_hits[c] = 0;
        m_start[c] = 0; m_stop[c] = 0; m_rep[c] = 1'b0;
      end
      e_cnt = 0; e_hits = 0; e_state = 0;
      return;
    end
    // Readback captures the pre-edge view of the selected channel.
    if (int'(rd_sel) < NCH) begin
      e_cnt = m_cnt[rd_sel]; e_hits = m_hits[rd_sel]; e_state = m_state[rd_sel];
    end else begin
      e_cnt = 0; e_hits = 0; e_state = 0;
    end
    for (int c = 0; c < NCH; c++) begin
      acc = cfg_we && (int'(cfg_sel) == c) &&
            (m_state[c] == ST_IDLE || m_state[c] == ST_DONE);
      if (clear[c]) begin
        m_state[c] = ST_IDLE; m_cnt[c] = 0; m_hits[c] = 0;
      end else if ((m_state[c] == ST_IDLE || m_state[c] == ST_DONE) && arm[c]) begin
        m_state[c] = ST_ARMED;
      end else if (m_state[c] == ST_ARMED && enable && int'(pc) == m_start[c]) begin
        m_state[c] = ST_RUN;
      end else if (m_state[c] == ST_RUN && enable) begin
        m_cnt[c]++;
        if (int'(pc) == m_stop[c]) begin
          m_hits[c]++;
          m_state[c] = m_rep[c] ? ST_ARMED : ST_DONE;
        end
      end
      if (acc) begin
        m_start[c] = int'(cfg_start); m_stop[c] = int'(cfg_stop); m_rep[c] = cfg_repeat;
      end
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] ed, eoa, eob;
    for (int c = 0; c < NCH; c++) begin
      ed[c]  = (m_state[c] == ST_DONE);
      eoa[c] = (m_cnt[c] > 255) || (m_hits[c] > 65535);
      eob[c] = (m_cnt[c] > 15)  || (m_hits[c] > 65535);
    end
    check("rd_count_a", rd_count_a, sat(e_cnt, 255));
    check("rd_count_b", rd_count_b, sat(e_cnt, 15));
    check("rd_hits_a",  rd_hits_a,  sat(e_hits, 65535));
    check("rd_hits_b",  rd_hits_b,  sat(e_hits, 65535));
    check("rd_state_a", rd_state_a, e_state);
    check("rd_state_b", rd_state_b, e_state);
    check("done_a",     done_a,     ed);
    check("done_b",     done_b,     ed);
    check("overflow_a", ovf_a,      eoa);
    check("overflow_b", ovf_b,      eob);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare();
    arm = '0; clear = '0; cfg_we = 1'b0;
  endtask

  task automatic configure(int ch, int s, int e, bit r);
    cfg_we = 1'b1; cfg_sel = SW'(ch); cfg_start = AW'(s); cfg_stop = AW'(e);
    cfg_repeat = r;
    cycle();
  endtask

  task automatic hold();
    enable = 1'b0;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; pc = '0; cfg_we = 1'b0; cfg_sel = '0;
    cfg_start = '0; cfg_stop = '0; cfg_repeat = 1'b0; arm = '0; clear = '0;
    rd_sel = '0;
    cycle(); cycle();
    check("reset_rd_count", rd_count_a, 0);
    check("reset_done", done_a, 0);
    reset = 1'b0;

    // Single window: 1..12 -> 11 cycles
    configure(0, 1, 12, 1'b0);
    arm = 3'b001; cycle();
    enable = 1'b1;
    for (int p = 0; p <= 12; p++) begin pc = AW'(p); cycle(); end
    pc = 8'd13; hold();
    check("lit_single_model", e_cnt, 11);
    check("single_count", rd_count_a, 11);
    check("single_hits", rd_hits_a, 1);
    check("single_state", rd_state_a, 3);
    check("single_done", done_a[0], 1);

    // Enable gating: three held cycles at pc=5 are not counted
    clear = 3'b001; cycle();
    arm = 3'b001; cycle();
    for (int p = 0; p <= 12; p++) begin
      enable = 1'b1; pc = AW'(p); cycle();
      if (p == 5) for (int k = 0; k < 3; k++) hold();
    end
    pc = 8'd13; hold();
    check("gate_count", rd_count_a, 11);
    check("gate_done", done_a[0], 1);

    // arm and clear together on DONE: clear wins
    arm = 3'b001; clear = 3'b001; cycle();
    hold();
    check("armclr_count", rd_count_a, 0);
    check("armclr_state", rd_state_a, 0);

    // Repeat accumulate: ch1 5..11 three times, then re-entry at pc=5
    rd_sel = 2'd1;
    configure(1, 5, 11, 1'b1);
    arm = 3'b010; cycle();
    enable = 1'b1;
    for (int l = 0; l < 3; l++)
      for (int p = 5; p <= 11; p++) begin pc = AW'(p); cycle(); end
    pc = 8'd5; cycle();
    hold();
    check("lit_repeat_model", e_cnt, 18);
    check("repeat_count", rd_count_a, 18);
    check("repeat_hits", rd_hits_a, 3);
    check("repeat_state", rd_state_a, 2);
    check("repeat_sat_b", rd_count_b, 15);
    check("repeat_ovf_b", ovf_b[1], 1);

    // Saturation: 20-cycle window on ch2
    rd_sel = 2'd2;
    configure(2, 32, 52, 1'b0);
    arm = 3'b100; cycle();
    enable = 1'b1;
    for (int p = 32; p <= 52; p++) begin pc = AW'(p); cycle(); end
    hold();
    check("sat_count_a", rd_count_a, 20);
    check("sat_count_b", rd_count_b, 15);
    check("sat_ovf_b", ovf_b[2], 1);
    check("sat_ovf_a", ovf_a[2], 0);
    check("sat_done_b", done_b[2], 1);
    clear = 3'b100; cycle();
    hold();
    check("satclr_count_b", rd_count_b, 0);
    check("satclr_ovf_b", ovf_b[2], 0);
    check("satclr_state", rd_state_b, 0);

    // cfg write while RUNNING is dropped
    configure(2, 64, 66, 1'b0);
    arm = 3'b100; cycle();
    enable = 1'b1; pc = 8'd64; cycle();
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_start = 8'd80; cfg_stop = 8'd96;
    pc = 8'd65; cycle();
    pc = 8'd66; cycle();
    hold();
    check("cfgrun_count", rd_count_a, 2);
    check("cfgrun_state", rd_state_a, 3);
    check("cfgrun_done", done_a[2], 1);

    // Out-of-range select
    rd_sel = 2'd3; cfg_we = 1'b1; cfg_sel = 2'd3; hold();
    check("oor_count", rd_count_a, 0);
    check("oor_state", rd_state_a, 0);

    // Reset mid-run
    rd_sel = 2'd0;
    configure(0, 112, 127, 1'b0);
    arm = 3'b001; cycle();
    enable = 1'b1;
    for (int p = 112; p <= 118; p++) begin pc = AW'(p); cycle(); end
    hold();
    check("midrun_count", rd_count_a, 6);
    check("midrun_state", rd_state_a, 2);
    reset = 1'b1; cycle();
    reset = 1'b0;
    check("rst_count", rd_count_a, 0);
    check("rst_state", rd_state_a, 0);
    check("rst_done", done_a, 0);
    check("rst_ovf_b", ovf_b, 0);

    // Randomized traffic over a small PC range so matches are frequent
    pc = '0;
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(599) == 0);
      enable = ($urandom_range(99) < 85);
      if ($urandom_range(1) == 1) pc = pc + 8'd1;
      else pc = AW'($urandom_range(15));
      if (pc > 8'd15) pc = '0;
      cfg_we     = ($urandom_range(9) == 0);
      cfg_sel    = SW'($urandom_range(3));
      cfg_start  = AW'($urandom_range(15));
      cfg_stop   = AW'($urandom_range(15));
      cfg_repeat = 1'($urandom_range(1));
      for (int c = 0; c < NCH; c++) begin
        arm[c]   = ($urandom_range(19) == 0);
        clear[c] = ($urandom_range(49) == 0);
      end
      if ($urandom_range(9) == 0) rd_sel = SW'($urandom_range(3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
